// File: rtl/systolic_feeder.sv
// Operand feeder for an N x N output-stationary systolic array: stores A and B row-wise,
// then clears the array, streams diagonally skewed rows/columns, drains, and pulses done.
module systolic_feeder #(
    parameter int unsigned N        = 4,
    parameter int unsigned NUM_BITS = 8,
    localparam int unsigned AW      = $clog2(N)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wr_en,
    input  logic                         wr_sel,
    input  logic [AW-1:0]                wr_row,
    input  logic [N-1:0][NUM_BITS-1:0]   wr_data,
    input  logic                         start,
    output logic                         busy,
    output logic                         done,
    output logic                         array_clr,
    output logic [N-1:0][NUM_BITS-1:0]   west_o,
    output logic [N-1:0][NUM_BITS-1:0]   north_o
);

    localparam int unsigned TW = $clog2(2 * N);
    localparam logic [TW-1:0] TLast = TW'(2 * N - 2);

    typedef enum logic [2:0] {StIdle, StClear, StStream, StDrain, StDone} state_e;

    state_e                              state_q, state_d;
    logic [TW-1:0]                       t_q, t_d;
    logic [N-1:0][N-1:0][NUM_BITS-1:0]   mem_a_q, mem_b_q;
    logic [N-1:0][NUM_BITS-1:0]          west_d, north_d;
    logic                                wr_ok;

    assign wr_ok = wr_en && (state_q == StIdle) && (32'(wr_row) < N);

    always_comb begin
        state_d = state_q;
        t_d     = '0;
        unique case (state_q)
            StIdle:   if (start) state_d = StClear;
            StClear:  state_d = StStream;
            StStream: begin
                if (t_q == TLast) state_d = StDrain;
                else              t_d     = t_q + 1'b1;
            end
            StDrain: begin
                if (t_q == TLast) state_d = StDone;
                else              t_d     = t_q + 1'b1;
            end
            StDone:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Stream values are computed from the next state so the registered outputs line up
    // with the cycle in which that state is current.
    always_comb begin
        west_d  = '0;
        north_d = '0;
        if (state_d == StStream) begin
            for (int i = 0; i < int'(N); i++) begin
                if (int'(t_d) >= i && int'(t_d) - i < int'(N)) begin
                    west_d[i]  = mem_a_q[i][AW'(int'(t_d) - i)];
                    north_d[i] = mem_b_q[AW'(int'(t_d) - i)][i];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            t_q       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            array_clr <= 1'b0;
            west_o    <= '0;
            north_o   <= '0;
        end else begin
            state_q   <= state_d;
            t_q       <= t_d;
            busy      <= (state_d != StIdle);
            done      <= (state_d == StDone);
            array_clr <= (state_d == StClear);
            west_o    <= west_d;
            north_o   <= north_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_a_q <= '0;
            mem_b_q <= '0;
        end else if (wr_ok) begin
            if (wr_sel) mem_b_q[wr_row] <= wr_data;
            else        mem_a_q[wr_row] <= wr_data;
        end
    end

endmodule

// File: tb/tb_systolic_feeder.sv
// Self-checking bench for systolic_feeder: directed vectors, skew table, and control corner cases.
module tb_systolic_feeder;

    localparam int N  = 4;
    localparam int NB = 8;

    logic                 clk, rst, wr_en, wr_sel, start;
    logic [1:0]           wr_row;
    logic [N-1:0][NB-1:0] wr_data;
    logic                 busy, done, array_clr;
    logic [N-1:0][NB-1:0] west_o, north_o;

    systolic_feeder #(.N(N), .NUM_BITS(NB)) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_sel    (wr_sel),
        .wr_row    (wr_row),
        .wr_data   (wr_data),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .array_clr (array_clr),
        .west_o    (west_o),
        .north_o   (north_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    int amat [N][N];
    int bmat [N][N];
    int cap_w [2*N-1][N];
    int cap_n [2*N-1][N];
    int n_done, done_c, done_abs, n_clr, clr_c, busy_first, busy_end;

    typedef struct {
        bit is_north;
        int t;
        int idx;
        int exp;
    } vec_t;
    vec_t vecs [12];

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic write_row(input bit sel, input int row, input int vals [N]);
        wr_en  = 1'b1;
        wr_sel = sel;
        wr_row = 2'(row);
        for (int k = 0; k < N; k++) wr_data[k] = NB'(vals[k]);
        tick();
        wr_en = 1'b0;
    endtask

    task automatic load_mats();
        for (int r = 0; r < N; r++) begin
            write_row(1'b0, r, amat[r]);
            write_row(1'b1, r, bmat[r]);
        end
    endtask

    // Runs one multiply from start through cycle 4N+1; optional write+start injection mid-run.
    task automatic run_op(input int inject_cyc);
        start = 1'b1;
        tick();
        start = 1'b0;
        n_done = 0; done_c = -1; done_abs = -1; n_clr = 0; clr_c = -1;
        busy_first = 0; busy_end = 1;
        for (int c = 1; c <= 4 * N + 1; c++) begin
            if (array_clr) begin n_clr++; clr_c = c; end
            if (done) begin
                n_done++;
                if (done_c < 0) begin done_c = c; done_abs = cyc; end
            end
            if (c >= 2 && c <= 2 * N)
                for (int i = 0; i < N; i++) begin
                    cap_w[c-2][i] = int'(west_o[i]);
                    cap_n[c-2][i] = int'(north_o[i]);
                end
            if (c == 1) busy_first = int'(busy);
            if (c == 4 * N + 1) busy_end = int'(busy);
            if (c == inject_cyc) begin
                wr_en = 1'b1; wr_sel = 1'b0; wr_row = 2'd0;
                for (int k = 0; k < N; k++) wr_data[k] = 8'd9;
                start = 1'b1;
            end else if (c == inject_cyc + 1) begin
                wr_en = 1'b0;
                start = 1'b0;
            end
            if (c < 4 * N + 1) tick();
        end
    endtask

    task automatic check_ctrl(input string tag);
        chk({tag, " clr_cycle"}, clr_c, 1);
        chk({tag, " clr_count"}, n_clr, 1);
        chk({tag, " busy_c1"}, busy_first, 1);
        chk({tag, " done_cycle"}, done_c, 4 * N);
        chk({tag, " done_count"}, n_done, 1);
        chk({tag, " busy_end"}, busy_end, 0);
    endtask

    // Output-stationary array model: PE(i,j) sees west[i] delayed j, north[j] delayed i.
    task automatic check_c(input string tag);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                int s, e;
                s = 0; e = 0;
                for (int tau = 0; tau < 4 * N; tau++) begin
                    int tw, tn;
                    tw = tau - j; tn = tau - i;
                    if (tw >= 0 && tw < 2 * N - 1 && tn >= 0 && tn < 2 * N - 1)
                        s += cap_w[tw][i] * cap_n[tn][j];
                end
                for (int k = 0; k < N; k++) e += amat[i][k] * bmat[k][j];
                chk($sformatf("%s C[%0d][%0d]", tag, i, j), s, e);
            end
    endtask

    task automatic check_table(input string tag);
        for (int v = 0; v < 12; v++) begin
            int act;
            act = vecs[v].is_north ? cap_n[vecs[v].t][vecs[v].idx]
                                   : cap_w[vecs[v].t][vecs[v].idx];
            chk($sformatf("%s %s[%0d] t=%0d", tag, vecs[v].is_north ? "north" : "west",
                          vecs[v].idx, vecs[v].t), act, vecs[v].exp);
        end
    endtask

    initial begin
        vecs[0]  = '{0, 3, 2, 21};
        vecs[1]  = '{1, 1, 1, 101};
        vecs[2]  = '{0, 2, 3, 0};
        vecs[3]  = '{1, 6, 3, 133};
        vecs[4]  = '{0, 0, 0, 0};
        vecs[5]  = '{0, 1, 0, 1};
        vecs[6]  = '{0, 4, 1, 13};
        vecs[7]  = '{0, 4, 0, 0};
        vecs[8]  = '{1, 0, 0, 100};
        vecs[9]  = '{1, 5, 2, 132};
        vecs[10] = '{0, 6, 3, 33};
        vecs[11] = '{1, 2, 3, 0};

        rst = 1'b0; wr_en = 1'b0; wr_sel = 1'b0; wr_row = '0; wr_data = '0; start = 1'b0;
        #13;
        chk("reset busy", int'(busy), 0);
        chk("reset done", int'(done), 0);
        chk("reset clr", int'(array_clr), 0);
        chk("reset west", int'(|west_o), 0);
        chk("reset north", int'(|north_o), 0);
        @(negedge clk);
        rst = 1'b1;
        tick();

        // Identity
        for (int i = 0; i < N; i++)
            for (int k = 0; k < N; k++) begin
                amat[i][k] = (i == k) ? 1 : 0;
                bmat[i][k] = (i == k) ? 1 : 0;
            end
        load_mats();
        run_op(-10);
        check_ctrl("ident");
        for (int t = 0; t < 2 * N - 1; t++)
            for (int i = 0; i < N; i++) begin
                chk($sformatf("ident west[%0d] t=%0d", i, t), cap_w[t][i], (t == 2 * i) ? 1 : 0);
                chk($sformatf("ident north[%0d] t=%0d", i, t), cap_n[t][i], (t == 2 * i) ? 1 : 0);
            end
        check_c("ident");

        // Skew data; write and start injected mid-stream must be ignored
        tick();
        for (int i = 0; i < N; i++)
            for (int k = 0; k < N; k++) begin
                amat[i][k] = 10 * i + k;
                bmat[i][k] = 100 + 10 * i + k;
            end
        load_mats();
        run_op(5);
        check_ctrl("gate");
        check_table("gate");
        check_c("gate");

        // Back-to-back: start in the IDLE cycle right after done
        begin
            int first_abs;
            first_abs = done_abs;
            run_op(-10);
            check_ctrl("b2b");
            chk("b2b done spacing", done_abs - first_abs, 4 * N + 1);
            check_table("b2b");
            check_c("b2b");
        end

        // Reset mid-stream at t=3 (cycle 5)
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c < 5; c++) tick();
        chk("pre-reset west[0] t=3", int'(west_o[0]), 3);
        rst = 1'b0;
        #1;
        chk("midrst busy", int'(busy), 0);
        chk("midrst west", int'(|west_o), 0);
        chk("midrst north", int'(|north_o), 0);
        chk("midrst done", int'(done), 0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        chk("post-rst busy", int'(busy), 0);
        run_op(-10);
        check_ctrl("postrst");
        begin
            int any;
            any = 0;
            for (int t = 0; t < 2 * N - 1; t++)
                for (int i = 0; i < N; i++) any |= cap_w[t][i] | cap_n[t][i];
            chk("postrst streams zero", any, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
